// File: rtl/branch_resolver.sv
// EX-stage branch resolver: queues fetch-side predictions in order, checks them at EX,
// raises flush/redirect on a mispredict and issues BTB update writes for direct CTIs.
module branch_resolver #(
  parameter int WORD_SIZE      = 16,
  parameter int BTB_INDEX_SIZE = 8,
  parameter int QDEPTH         = 4,
  parameter int CNT_W          = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                stall,
  input  logic                                if_valid,
  input  logic [WORD_SIZE-1:0]                if_pc,
  input  logic [WORD_SIZE-1:0]                if_pred_pc,
  input  logic                                if_pred_hit,
  input  logic                                ex_valid,
  input  logic                                ex_is_branch,
  input  logic                                ex_taken,
  input  logic                                ex_is_jump,
  input  logic                                ex_is_jr,
  input  logic [WORD_SIZE-1:0]                ex_target,
  input  logic [WORD_SIZE-1:0]                ex_rs_value,
  output logic                                flush,
  output logic [WORD_SIZE-1:0]                redirect_pc,
  output logic                                btb_wr_en,
  output logic [BTB_INDEX_SIZE-1:0]           btb_wr_index,
  output logic [WORD_SIZE-BTB_INDEX_SIZE-1:0] btb_wr_tag,
  output logic [WORD_SIZE-1:0]                btb_wr_target,
  output logic                                q_full,
  output logic                                q_empty,
  output logic                                err_overflow,
  output logic                                err_underflow,
  output logic [CNT_W-1:0]                    branch_count,
  output logic [CNT_W-1:0]                    mispredict_count
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int TAG_W = WORD_SIZE - BTB_INDEX_SIZE;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(QDEPTH);

  logic [WORD_SIZE-1:0]      pcMem_q   [QDEPTH];
  logic [WORD_SIZE-1:0]      predMem_q [QDEPTH];
  logic [QDEPTH-1:0]         hitMem_q;
  logic [PTR_W-1:0]          head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]            count_q, count_d;
  logic                      flush_q, btbWr_q, errOvf_q, errUnd_q;
  logic [WORD_SIZE-1:0]      redirect_q, btbTarget_q;
  logic [BTB_INDEX_SIZE-1:0] btbIndex_q;
  logic [TAG_W-1:0]          btbTag_q;
  logic [CNT_W-1:0]          branchCnt_q, misCnt_q;

  logic [WORD_SIZE-1:0] headPc, headPred, actualPc;
  logic                 headHit, qFull, qEmpty;
  logic                 popEn, pushReq, pushEn, mispredict, kill, isCti, btbWr;

  assign qFull  = (count_q == FULL_CNT);
  assign qEmpty = (count_q == '0);

  // A pending flush blocks resolution, so a mispredict can never follow another directly.
  always_comb begin
    headPc   = pcMem_q[head_q];
    headPred = predMem_q[head_q];
    headHit  = hitMem_q[head_q];
    popEn    = ex_valid & ~qEmpty & ~flush_q;
    isCti    = ex_is_branch | ex_is_jump | ex_is_jr;
    if (ex_is_jr)
      actualPc = ex_rs_value;
    else if (ex_is_jump | (ex_is_branch & ex_taken))
      actualPc = ex_target;
    else
      actualPc = headPc + WORD_SIZE'(1);
    mispredict = popEn & (actualPc != headPred);
    kill       = mispredict | flush_q;
    pushReq    = if_valid & ~stall;
    pushEn     = pushReq & ~qFull & ~kill;
    btbWr      = popEn & (ex_is_jump | (ex_is_branch & ex_taken)) & ~ex_is_jr &
                 (~headHit | (headPred != ex_target));
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (kill) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (popEn)  head_d = head_q + PTR_W'(1);
      if (pushEn) tail_d = tail_q + PTR_W'(1);
      if (pushEn & ~popEn) count_d = count_q + (PTR_W+1)'(1);
      else if (popEn & ~pushEn) count_d = count_q - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < QDEPTH; i++) begin
        pcMem_q[i]   <= '0;
        predMem_q[i] <= '0;
      end
      hitMem_q    <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      flush_q     <= 1'b0;
      redirect_q  <= '0;
      btbWr_q     <= 1'b0;
      btbIndex_q  <= '0;
      btbTag_q    <= '0;
      btbTarget_q <= '0;
      errOvf_q    <= 1'b0;
      errUnd_q    <= 1'b0;
      branchCnt_q <= '0;
      misCnt_q    <= '0;
    end else begin
      if (pushEn) begin
        pcMem_q[tail_q]   <= if_pc;
        predMem_q[tail_q] <= if_pred_pc;
        hitMem_q[tail_q]  <= if_pred_hit;
      end
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      flush_q     <= mispredict;
      redirect_q  <= mispredict ? actualPc : '0;
      btbWr_q     <= btbWr;
      btbIndex_q  <= btbWr ? headPc[BTB_INDEX_SIZE-1:0] : '0;
      btbTag_q    <= btbWr ? headPc[WORD_SIZE-1:BTB_INDEX_SIZE] : '0;
      btbTarget_q <= btbWr ? ex_target : '0;
      if (pushReq & qFull) errOvf_q <= 1'b1;
      if (ex_valid & qEmpty & ~flush_q) errUnd_q <= 1'b1;
      if (popEn & isCti & (branchCnt_q != '1)) branchCnt_q <= branchCnt_q + CNT_W'(1);
      if (mispredict & (misCnt_q != '1)) misCnt_q <= misCnt_q + CNT_W'(1);
    end
  end

  assign flush            = flush_q;
  assign redirect_pc      = redirect_q;
  assign btb_wr_en        = btbWr_q;
  assign btb_wr_index     = btbIndex_q;
  assign btb_wr_tag       = btbTag_q;
  assign btb_wr_target    = btbTarget_q;
  assign q_full           = qFull;
  assign q_empty          = qEmpty;
  assign err_overflow     = errOvf_q;
  assign err_underflow    = errUnd_q;
  assign branch_count     = branchCnt_q;
  assign mispredict_count = misCnt_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed vector table, hand-written corner
// sequences and randomized traffic compared against a queue-based reference model.
module tb_branch_resolver;

  localparam int WS   = 16;
  localparam int IDX  = 8;
  localparam int QD   = 4;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic stall = 1'b0, if_valid = 1'b0, if_pred_hit = 1'b0;
  logic [WS-1:0] if_pc = '0, if_pred_pc = '0, ex_target = '0, ex_rs_value = '0;
  logic ex_valid = 1'b0, ex_is_branch = 1'b0, ex_taken = 1'b0, ex_is_jump = 1'b0, ex_is_jr = 1'b0;
  logic flush, btb_wr_en, q_full, q_empty, err_overflow, err_underflow;
  logic [WS-1:0] redirect_pc, btb_wr_target;
  logic [IDX-1:0] btb_wr_index;
  logic [WS-IDX-1:0] btb_wr_tag;
  logic [CW-1:0] branch_count, mispredict_count;

  branch_resolver #(.WORD_SIZE(WS), .BTB_INDEX_SIZE(IDX), .QDEPTH(QD), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .if_valid(if_valid), .if_pc(if_pc),
    .if_pred_pc(if_pred_pc), .if_pred_hit(if_pred_hit), .ex_valid(ex_valid),
    .ex_is_branch(ex_is_branch), .ex_taken(ex_taken), .ex_is_jump(ex_is_jump),
    .ex_is_jr(ex_is_jr), .ex_target(ex_target), .ex_rs_value(ex_rs_value),
    .flush(flush), .redirect_pc(redirect_pc), .btb_wr_en(btb_wr_en),
    .btb_wr_index(btb_wr_index), .btb_wr_tag(btb_wr_tag), .btb_wr_target(btb_wr_target),
    .q_full(q_full), .q_empty(q_empty), .err_overflow(err_overflow),
    .err_underflow(err_underflow), .branch_count(branch_count),
    .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: an in-order list of predictions plus the expected registered outputs.
  typedef struct {
    logic [WS-1:0] pc;
    logic [WS-1:0] pred;
    logic          hit;
  } ent_t;

  ent_t mq[$];
  bit mFlush, mWr, mOvf, mUnd;
  logic [WS-1:0] mRedir, mTgt;
  logic [IDX-1:0] mIdx;
  logic [WS-IDX-1:0] mTag;
  int mBr, mMis;

  function automatic void modelClear();
    mq.delete();
    mFlush = 0; mWr = 0; mOvf = 0; mUnd = 0;
    mRedir = '0; mTgt = '0; mIdx = '0; mTag = '0;
    mBr = 0; mMis = 0;
  endfunction

  function automatic void modelStep();
    bit popOk, mis, wr, pushReq, wasFull;
    logic [WS-1:0] act;
    ent_t e;
    popOk   = ex_valid && (mq.size() > 0) && !mFlush;
    wasFull = (mq.size() == QD);
    pushReq = if_valid && !stall;
    mis = 0;
    wr  = 0;
    act = '0;
    if (ex_valid && mq.size() == 0 && !mFlush) mUnd = 1;
    if (pushReq && wasFull) mOvf = 1;
    if (popOk) begin
      e = mq[0];
      if (ex_is_jr) act = ex_rs_value;
      else if (ex_is_jump || (ex_is_branch && ex_taken)) act = ex_target;
      else act = e.pc + 16'd1;
      mis = (act != e.pred);
      wr  = (ex_is_jump || (ex_is_branch && ex_taken)) && !ex_is_jr &&
            (!e.hit || e.pred != ex_target);
      if ((ex_is_branch || ex_is_jump || ex_is_jr) && mBr < CMAX) mBr++;
      if (mis && mMis < CMAX) mMis++;
      if (wr) begin
        mIdx = e.pc[IDX-1:0];
        mTag = e.pc[WS-1:IDX];
        mTgt = ex_target;
      end
    end
    if (mis || mFlush) begin
      mq.delete();
    end else begin
      if (popOk) void'(mq.pop_front());
      if (pushReq && !wasFull) mq.push_back('{pc: if_pc, pred: if_pred_pc, hit: if_pred_hit});
    end
    mFlush = mis;
    mRedir = act;
    mWr    = wr;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic compareModel();
    checkOutput("m_flush", 32'(flush), 32'(mFlush));
    if (mFlush) checkOutput("m_redirect", 32'(redirect_pc), 32'(mRedir));
    checkOutput("m_btb_wr_en", 32'(btb_wr_en), 32'(mWr));
    if (mWr) begin
      checkOutput("m_btb_index", 32'(btb_wr_index), 32'(mIdx));
      checkOutput("m_btb_tag", 32'(btb_wr_tag), 32'(mTag));
      checkOutput("m_btb_target", 32'(btb_wr_target), 32'(mTgt));
    end
    checkOutput("m_q_full", 32'(q_full), 32'(mq.size() == QD));
    checkOutput("m_q_empty", 32'(q_empty), 32'(mq.size() == 0));
    checkOutput("m_err_overflow", 32'(err_overflow), 32'(mOvf));
    checkOutput("m_err_underflow", 32'(err_underflow), 32'(mUnd));
    checkOutput("m_branch_count", 32'(branch_count), 32'(mBr));
    checkOutput("m_mispredict_count", 32'(mispredict_count), 32'(mMis));
  endtask

  // One clock: model sees the same inputs the DUT samples, outputs are compared mid-cycle.
  task automatic tick();
    modelStep();
    @(posedge clk);
    @(negedge clk);
    compareModel();
  endtask

  task automatic idle();
    stall = 0; if_valid = 0; if_pred_hit = 0; if_pc = '0; if_pred_pc = '0;
    ex_valid = 0; ex_is_branch = 0; ex_taken = 0; ex_is_jump = 0; ex_is_jr = 0;
    ex_target = '0; ex_rs_value = '0;
  endtask

  task automatic applyStimulus(input logic [WS-1:0] pc, input logic [WS-1:0] pred, input logic hit);
    idle();
    if_valid = 1; if_pc = pc; if_pred_pc = pred; if_pred_hit = hit;
  endtask

  task automatic resolve(input logic br, input logic tk, input logic jmp, input logic jr,
                         input logic [WS-1:0] tgt, input logic [WS-1:0] rs);
    idle();
    ex_valid = 1; ex_is_branch = br; ex_taken = tk; ex_is_jump = jmp; ex_is_jr = jr;
    ex_target = tgt; ex_rs_value = rs;
  endtask

  task automatic doReset();
    idle();
    reset = 1;
    modelClear();
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    compareModel();
  endtask

  typedef struct {
    logic [WS-1:0] pc, pred;
    logic hit, br, tk, jmp, jr;
    logic [WS-1:0] tgt, rs;
    logic eFlush;
    logic [WS-1:0] eRedir;
    logic eWr;
    logic [IDX-1:0] eIdx;
    logic [WS-IDX-1:0] eTag;
    logic [WS-1:0] eTgt;
  } vec_t;

  vec_t vecs[8];

  initial begin
    // pc, pred, hit, br, tk, jmp, jr, tgt, rs, flush, redirect, wr, idx, tag, target
    vecs[0] = '{16'h000A, 16'h000B, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 8'h00, 8'h00, 16'h0000};
    vecs[1] = '{16'h0120, 16'h0121, 0, 1, 1, 0, 0, 16'h0200, 16'h0000, 1, 16'h0200, 1, 8'h20, 8'h01, 16'h0200};
    vecs[2] = '{16'h0030, 16'h0031, 0, 0, 0, 0, 1, 16'h0000, 16'h4000, 1, 16'h4000, 0, 8'h00, 8'h00, 16'h0000};
    vecs[3] = '{16'hFFFF, 16'h0000, 0, 1, 0, 0, 0, 16'h0050, 16'h0000, 0, 16'h0000, 0, 8'h00, 8'h00, 16'h0000};
    vecs[4] = '{16'h0500, 16'h0777, 1, 0, 0, 1, 0, 16'h0777, 16'h0000, 0, 16'h0000, 0, 8'h00, 8'h00, 16'h0000};
    vecs[5] = '{16'h0600, 16'h0800, 0, 0, 0, 1, 0, 16'h0800, 16'h0000, 0, 16'h0000, 1, 8'h00, 8'h06, 16'h0800};
    vecs[6] = '{16'h1234, 16'h1235, 1, 1, 1, 0, 0, 16'h1000, 16'h0000, 1, 16'h1000, 1, 8'h34, 8'h12, 16'h1000};
    vecs[7] = '{16'h2000, 16'h2100, 1, 1, 0, 0, 0, 16'h2100, 16'h0000, 1, 16'h2001, 0, 8'h00, 8'h00, 16'h0000};

    reset = 1;
    modelClear();
    #2;
    checkOutput("reset_q_empty", 32'(q_empty), 32'd1);
    checkOutput("reset_flush", 32'(flush), 32'd0);
    @(negedge clk);
    reset = 0;
    compareModel();

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].pc, vecs[i].pred, vecs[i].hit);
      tick();
      resolve(vecs[i].br, vecs[i].tk, vecs[i].jmp, vecs[i].jr, vecs[i].tgt, vecs[i].rs);
      tick();
      checkOutput($sformatf("vec%0d_flush", i), 32'(flush), 32'(vecs[i].eFlush));
      if (vecs[i].eFlush) checkOutput($sformatf("vec%0d_redirect", i), 32'(redirect_pc), 32'(vecs[i].eRedir));
      checkOutput($sformatf("vec%0d_btb_wr_en", i), 32'(btb_wr_en), 32'(vecs[i].eWr));
      if (vecs[i].eWr) begin
        checkOutput($sformatf("vec%0d_btb_index", i), 32'(btb_wr_index), 32'(vecs[i].eIdx));
        checkOutput($sformatf("vec%0d_btb_tag", i), 32'(btb_wr_tag), 32'(vecs[i].eTag));
        checkOutput($sformatf("vec%0d_btb_target", i), 32'(btb_wr_target), 32'(vecs[i].eTgt));
      end
      checkOutput($sformatf("vec%0d_q_empty", i), 32'(q_empty), 32'd1);
      idle();
      tick();
    end
    checkOutput("table_mispredict_count", 32'(mispredict_count), 32'd4);
    checkOutput("table_branch_count", 32'(branch_count), 32'd7);

    // Asynchronous reset landing while a flush pulse is visible.
    applyStimulus(16'h0040, 16'h0041, 1);
    tick();
    resolve(0, 0, 1, 0, 16'h0900, 16'h0000);
    tick();
    checkOutput("pre_reset_flush", 32'(flush), 32'd1);
    #2;
    reset = 1;
    #1;
    checkOutput("async_q_empty", 32'(q_empty), 32'd1);
    checkOutput("async_flush", 32'(flush), 32'd0);
    checkOutput("async_branch_count", 32'(branch_count), 32'd0);
    checkOutput("async_mispredict_count", 32'(mispredict_count), 32'd0);
    idle();
    modelClear();
    @(negedge clk);
    reset = 0;
    compareModel();

    // Kill: head mispredicts with three entries queued and a push in the same cycle.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(16'h0100 + 16'(i), 16'h0101 + 16'(i), 1);
      tick();
    end
    resolve(0, 0, 1, 0, 16'h0300, 16'h0000);
    if_valid = 1; if_pc = 16'h0103; if_pred_pc = 16'h0104;
    tick();
    checkOutput("kill_flush", 32'(flush), 32'd1);
    checkOutput("kill_redirect", 32'(redirect_pc), 32'h0300);
    checkOutput("kill_q_empty", 32'(q_empty), 32'd1);
    resolve(0, 0, 1, 0, 16'h0300, 16'h0000);
    tick();
    checkOutput("kill_ignored_flush", 32'(flush), 32'd0);
    checkOutput("kill_ignored_underflow", 32'(err_underflow), 32'd0);
    checkOutput("kill_ignored_count", 32'(mispredict_count), 32'd1);
    idle();
    tick();

    // Overflow and underflow.
    doReset();
    for (int i = 0; i < QD + 1; i++) begin
      applyStimulus(16'h0200 + 16'(i), 16'h0201 + 16'(i), 0);
      tick();
      if (i == QD - 1) begin
        checkOutput("ovf_full", 32'(q_full), 32'd1);
        checkOutput("ovf_not_yet", 32'(err_overflow), 32'd0);
      end
    end
    checkOutput("ovf_flag", 32'(err_overflow), 32'd1);
    doReset();
    checkOutput("ovf_cleared", 32'(err_overflow), 32'd0);
    resolve(1, 1, 0, 0, 16'h0000, 16'h0000);
    tick();
    checkOutput("udf_flag", 32'(err_underflow), 32'd1);
    idle();
    tick();
    checkOutput("udf_sticky", 32'(err_underflow), 32'd1);

    // Counter saturation through repeated JR mispredicts.
    doReset();
    for (int i = 0; i < CMAX + 5; i++) begin
      applyStimulus(16'(i), 16'h0000, 1);
      tick();
      resolve(0, 0, 0, 1, 16'h0000, 16'h4000);
      tick();
      idle();
      tick();
    end
    checkOutput("sat_branch_count", 32'(branch_count), 32'(CMAX));
    checkOutput("sat_mispredict_count", 32'(mispredict_count), 32'(CMAX));

    // Randomized traffic.
    doReset();
    for (int c = 0; c < 3000; c++) begin
      int kind;
      idle();
      stall    = ($urandom_range(0, 7) == 0);
      if_valid = ($urandom_range(0, 3) != 0);
      if_pc    = 16'($urandom_range(0, 16'hFFFF));
      if_pred_hit = $urandom_range(0, 1);
      if_pred_pc  = ($urandom_range(0, 1) == 1) ? if_pc + 16'd1 : 16'($urandom_range(0, 15) << 4);
      ex_valid = ($urandom_range(0, 2) != 0);
      kind = $urandom_range(0, 4);
      ex_is_branch = (kind == 1 || kind == 2);
      ex_taken     = (kind == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      ex_is_jump   = (kind == 3);
      ex_is_jr     = (kind == 4);
      ex_target    = (mq.size() > 0 && $urandom_range(0, 1) == 1) ? mq[0].pred : 16'($urandom_range(0, 15) << 4);
      ex_rs_value  = (mq.size() > 0 && $urandom_range(0, 1) == 1) ? mq[0].pred : 16'($urandom_range(0, 16'hFFFF));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
